// File: rtl/phase_step_arbiter.sv
// Round-robin owner of a shared 3-phase stepping register (00->01->10->00) for NREQ clients.
// Latency: 1 cycle from sampled req to registered gnt; phase/phase_wrap update 1 cycle after step.
// Backpressure: tenure ends on req drop or MAX_HOLD cycles, followed by GAP cooldown cycles with no grant.
module phase_step_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 8,
    parameter int GAP      = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           step,
    output logic [NREQ-1:0]           gnt,
    output logic                      gnt_valid,
    output logic [$clog2(NREQ)-1:0]   gnt_id,
    output logic [1:0]                phase,
    output logic                      phase_wrap,
    output logic                      timeout
);

    localparam int IDW = $clog2(NREQ);
    localparam int HW  = $clog2(MAX_HOLD + 1);
    localparam int CW  = $clog2(GAP + 1);

    localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ - 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [CW-1:0]  COOL_LAST = CW'(GAP - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        COOL  = 2'b10
    } ctrl_t;

    ctrl_t           ctrl;
    logic [IDW-1:0]  ptr;
    logic [HW-1:0]   hold_cnt;
    logic [CW-1:0]   cool_cnt;

    logic            found;
    logic [IDW-1:0]  pick;
    logic [IDW-1:0]  cand;
    logic [NREQ-1:0] pick_oh;
    logic [IDW-1:0]  next_ptr;
    int              sum;

    assign gnt_valid = |gnt;

    // Pointer advances past the current grantee so it goes to the back of the line.
    assign next_ptr = (gnt_id == LAST_ID) ? '0 : gnt_id + IDW'(1);

    // Round-robin search: first requesting index at or after ptr, wrapping modulo NREQ.
    always_comb begin
        found   = 1'b0;
        pick    = '0;
        cand    = '0;
        sum     = 0;
        pick_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = int'(ptr) + i;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            cand = IDW'(sum);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        pick_oh[pick] = found;
    end

    // Controller, phase register and pulse outputs, all registered together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl       <= IDLE;
            gnt        <= '0;
            gnt_id     <= '0;
            phase      <= 2'b00;
            phase_wrap <= 1'b0;
            timeout    <= 1'b0;
            ptr        <= '0;
            hold_cnt   <= '0;
            cool_cnt   <= '0;
        end else begin
            phase_wrap <= 1'b0;
            timeout    <= 1'b0;
            case (ctrl)
                IDLE: begin
                    if (found) begin
                        ctrl     <= GRANT;
                        gnt      <= pick_oh;
                        gnt_id   <= pick;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    // Only the grantee may advance the phase; a step on the exit edge still counts.
                    if (step[gnt_id]) begin
                        case (phase)
                            2'b00:   phase <= 2'b01;
                            2'b01:   phase <= 2'b10;
                            2'b10: begin
                                phase      <= 2'b00;
                                phase_wrap <= 1'b1;
                            end
                            default: phase <= 2'b00;
                        endcase
                    end
                    if (!req[gnt_id]) begin
                        ctrl     <= COOL;
                        gnt      <= '0;
                        ptr      <= next_ptr;
                        cool_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        ctrl     <= COOL;
                        gnt      <= '0;
                        ptr      <= next_ptr;
                        cool_cnt <= '0;
                        timeout  <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                COOL: begin
                    if (cool_cnt == COOL_LAST) begin
                        ctrl <= IDLE;
                    end else begin
                        cool_cnt <= cool_cnt + CW'(1);
                    end
                end
                default: begin
                    ctrl <= IDLE;
                    gnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase_step_arbiter.sv
// Bench for phase_step_arbiter: directed scenarios plus randomized traffic against a tenure-level model.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: model tracks tenure owner, age and remaining cooldown explicitly.
module tb_phase_step_arbiter;

    localparam int NREQ     = 4;
    localparam int MAX_HOLD = 8;
    localparam int GAP      = 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] step = '0;
    logic [NREQ-1:0] gnt;
    logic            gnt_valid;
    logic [1:0]      gnt_id;
    logic [1:0]      phase;
    logic            phase_wrap;
    logic            timeout;

    int checks = 0;
    int errors = 0;

    phase_step_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD), .GAP(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .step       (step),
        .gnt        (gnt),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id),
        .phase      (phase),
        .phase_wrap (phase_wrap),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Tenure-level reference model.
    int m_owner;   // -1 when nobody holds the resource
    int m_age;     // grant cycles already spent in the current tenure
    int m_cool;    // cooldown cycles still to run before requests are looked at
    int m_start;   // first index to try in the next arbitration
    int m_id;
    int m_ph;      // 0,1,2 for phases 00,01,10
    bit m_wrap;
    bit m_to;

    wire [10:0] obs = {gnt, gnt_valid, gnt_id, phase, phase_wrap, timeout};

    function automatic logic [10:0] model_vec();
        logic [3:0] g;
        g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        return {g, (m_owner >= 0), 2'(m_id), 2'(m_ph), m_wrap, m_to};
    endfunction

    task automatic model_step();
        int c;
        if (!rst_n) begin
            m_owner = -1; m_age = 0; m_cool = 0; m_start = 0;
            m_id = 0; m_ph = 0; m_wrap = 0; m_to = 0;
        end else begin
            m_wrap = 0;
            m_to   = 0;
            if (m_owner >= 0) begin
                if (step[m_owner]) begin
                    m_wrap = (m_ph == 2);
                    m_ph   = (m_ph + 1) % 3;
                end
                if (!req[m_owner] || m_age == MAX_HOLD) begin
                    m_to    = req[m_owner];
                    m_start = (m_owner + 1) % NREQ;
                    m_owner = -1;
                    m_cool  = GAP;
                end else begin
                    m_age++;
                end
            end else if (m_cool > 0) begin
                m_cool--;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    c = (m_start + k) % NREQ;
                    if (m_owner < 0 && req[c]) begin
                        m_owner = c;
                        m_id    = c;
                        m_age   = 1;
                    end
                end
            end
        end
    endtask

    // Apply inputs for one cycle, advance the model on the edge, settle past the edge.
    task automatic tick(input logic [3:0] r, input logic [3:0] s);
        req  = r;
        step = s;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(4'b0000, 4'b0000);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs !== 11'b0) begin
            errors++;
            $display("FAIL reset_state got=%b want=%b", obs, 11'b0);
        end
        tick(4'b0000, 4'b0000);
        checks++;
        if (obs !== model_vec()) begin
            errors++;
            $display("FAIL reset_idle got=%b want=%b", obs, model_vec());
        end
    endtask

    task automatic test_handoff();
        logic [3:0] want [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0100};
        logic [3:0] rq   [6] = '{4'b0101, 4'b0101, 4'b0101, 4'b0100, 4'b0100, 4'b0100};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick(rq[i], 4'b0000);
            checks++;
            if (gnt !== want[i] || obs !== model_vec()) begin
                errors++;
                $display("FAIL handoff_cycle%0d gnt=%b want=%b obs=%b model=%b",
                         i + 1, gnt, want[i], obs, model_vec());
            end
        end
        for (int i = 0; i < 3; i++) tick(4'b0000, 4'b0000);
    endtask

    task automatic test_phase_steps();
        logic [1:0] wph [4] = '{2'b01, 2'b10, 2'b00, 2'b01};
        logic       wwr [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        tick(4'b0001, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            tick(4'b0001, 4'b0011);
            checks++;
            if (phase !== wph[i] || phase_wrap !== wwr[i] || obs !== model_vec()) begin
                errors++;
                $display("FAIL phase_step%0d phase=%b wrap=%b want_phase=%b want_wrap=%b",
                         i, phase, phase_wrap, wph[i], wwr[i]);
            end
        end
        tick(4'b0001, 4'b0010);
        checks++;
        if (phase !== 2'b01 || phase_wrap !== 1'b0) begin
            errors++;
            $display("FAIL phase_nongrantee phase=%b wrap=%b want_phase=01 want_wrap=0", phase, phase_wrap);
        end
        for (int i = 0; i < 3; i++) tick(4'b0000, 4'b0000);
    endtask

    task automatic test_timeout();
        tick(4'b0010, 4'b0000);
        for (int i = 0; i < MAX_HOLD - 1; i++) begin
            tick(4'b0010, 4'b0000);
            checks++;
            if (gnt !== 4'b0010 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL timeout_hold%0d gnt=%b timeout=%b want gnt=0010 timeout=0", i, gnt, timeout);
            end
        end
        tick(4'b0010, 4'b0000);
        checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b1 || obs !== model_vec()) begin
            errors++;
            $display("FAIL timeout_end gnt=%b timeout=%b want gnt=0000 timeout=1", gnt, timeout);
        end
        tick(4'b0010, 4'b0000);
        checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_cool gnt=%b timeout=%b want gnt=0000 timeout=0", gnt, timeout);
        end
        tick(4'b0010, 4'b0000);
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL timeout_regrant gnt=%b want=0010", gnt);
        end
        for (int i = 0; i < 3; i++) tick(4'b0000, 4'b0000);
    endtask

    task automatic test_round_robin();
        logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int waited;
        do_reset();
        for (int t = 0; t < 5; t++) begin
            waited = 0;
            while (gnt === 4'b0000 && waited < 6) begin
                tick(4'b1111, 4'b0000);
                waited++;
            end
            checks++;
            if (gnt !== order[t] || obs !== model_vec()) begin
                errors++;
                $display("FAIL rr_tenure%0d gnt=%b want=%b", t, gnt, order[t]);
            end
            tick(4'b1111 & ~gnt, 4'b0000);
        end
        for (int i = 0; i < 3; i++) tick(4'b0000, 4'b0000);
    endtask

    task automatic test_reset_mid_tenure();
        do_reset();
        tick(4'b0100, 4'b0000);
        tick(4'b0100, 4'b0100);
        tick(4'b0100, 4'b0100);
        checks++;
        if (phase !== 2'b10 || gnt !== 4'b0100) begin
            errors++;
            $display("FAIL midrst_setup phase=%b gnt=%b want phase=10 gnt=0100", phase, gnt);
        end
        rst_n = 1'b0;
        tick(4'b1010, 4'b0000);
        rst_n = 1'b1;
        checks++;
        if (gnt !== 4'b0000 || phase !== 2'b00 || gnt_id !== 2'b00) begin
            errors++;
            $display("FAIL midrst_clear gnt=%b phase=%b gnt_id=%b want 0000/00/00", gnt, phase, gnt_id);
        end
        tick(4'b1010, 4'b0000);
        checks++;
        if (gnt !== 4'b0010 || gnt_id !== 2'b01) begin
            errors++;
            $display("FAIL midrst_regrant gnt=%b gnt_id=%b want 0010/01", gnt, gnt_id);
        end
        for (int i = 0; i < 3; i++) tick(4'b0000, 4'b0000);
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic [3:0] s;
        int bad;
        r   = 4'b0000;
        bad = 0;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
            end
            s = 4'($urandom);
            rst_n = ($urandom_range(0, 399) != 0);
            tick(r, s);
            rst_n = 1'b1;
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                if (bad < 10) begin
                    $display("FAIL random_cycle%0d got=%b want=%b req=%b step=%b", n, obs, model_vec(), r, s);
                end
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_handoff();
        test_phase_steps();
        test_timeout();
        test_round_robin();
        test_reset_mid_tenure();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
